pe_sum_drain: RTL and testbench
===============================

Name: pe_sum_drain

Overview:
- Reader side of the PE sum registers: on `start`, snapshots the registered 20-bit partial sums of all PEs in a row.
- Quantizes each sum with an arithmetic right shift, optional ReLU and signed saturation.
- Streams the results out one per handshake on a valid/ready interface toward the output buffer / writeback path.
- Sits between the PE register column and the activation SRAM writer.

Parameters:
- NUM_PE, 16, number of PE sums captured per snapshot.
- IN_W, 20, width of each signed PE sum.
- OUT_W, 8, width of each signed quantized output.
- IDX_W, $clog2(NUM_PE), width of the element index.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to snapshot and drain; honoured only in IDLE.
- pe_sums  input  NUM_PE*IN_W  flattened registered PE sums; element i at bits [i*IN_W +: IN_W].
- shamt  input  5  right-shift amount, latched at start.
- relu_en  input  1  clamp negatives to 0, latched at start.
- out_valid  output  1  out_data holds a valid element.
- out_ready  input  1  downstream accepts the element.
- out_data  output  OUT_W  quantized signed element.
- out_idx  output  IDX_W  index of the current element.
- out_last  output  1  current element is index NUM_PE-1.
- busy  output  1  high in STREAM and DONE.
- done  output  1  one-cycle pulse after the last handshake.

Behaviour:
- Clock and reset: one clock. reset is asynchronous and active-high; all state is cleared immediately on assertion.
- Reset values: state=IDLE, all outputs 0, snapshot buffer 0, idx 0, shamt_q 0, relu_q 0.
- State machine, IDLE -> STREAM -> DONE -> IDLE.
- IDLE:
  - On start=1, on the same edge: capture all pe_sums into the buffer, latch shamt_q and relu_q, set idx=0, go to STREAM.
  - out_valid therefore rises on the cycle after start (latency 1).
- STREAM:
  - out_valid=1, out_idx=idx, out_last=(idx==NUM_PE-1), out_data=quant(buf[idx]).
  - Handshake = out_valid && out_ready.
  - On a handshake with !out_last: idx++.
  - On a handshake with out_last: go to DONE.
  - Without a handshake, out_data, out_idx and out_last stay stable.
- DONE: done=1 and out_valid=0 for exactly one cycle, then IDLE. The earliest new start is the cycle after done.
- start when not in IDLE is ignored; no queuing.
- pe_sums changes after capture have no effect on the stream.
- All outputs derive only from registered state; there is no combinational path from out_ready, start or pe_sums to any output.
- quant(x):
  - s = x >>> shamt_q, signed arithmetic shift, truncation toward -inf.
  - shamt_q >= IN_W gives 0 or -1.
  - If relu_q and s<0: s=0.
  - If s > 2^(OUT_W-1)-1: out = 2^(OUT_W-1)-1.
  - If s < -2^(OUT_W-1): out = -2^(OUT_W-1).
  - Otherwise out = s[OUT_W-1:0].
- Throughput: with out_ready held 1, NUM_PE elements in NUM_PE consecutive cycles. Total start-to-done = NUM_PE+1 cycles.
- Reset mid-stream: out_valid drops asynchronously and no done pulse is produced. The next start restarts at element 0.

Decomposition:
- Shared package pe_drain_pkg:
  - State encoding constants IDLE/STREAM/DONE (2 bits).
  - Defaults for IN_W and OUT_W.
  - SAT_MAX/SAT_MIN localparams derived from OUT_W.
- One combinational sub-module, pe_sum_quant, instantiated once on the selected element:
  - Inputs: IN_W sum, shamt, relu_en.
  - Output: OUT_W result.
- The FSM, buffer, index counter and handshake stay in pe_sum_drain.

Test Plan:
1. pe_sums element i = i, shamt=0, relu_en=0, out_ready=1, pulse start → out_data 0..15 on 16 consecutive cycles starting 1 cycle after start; out_last only with 15; done pulses on cycle 17.
2. Saturation/rounding, shamt=4: 20'h7FFFF → 8'h7F; 20'h80000 → 8'h80. With shamt=1: 300 → 8'h7F; -256 → 8'h80; -3 → 8'hFE.
3. Backpressure: out_ready toggling 1,0,1,0… → each element held stable while !out_ready; exactly 16 handshakes, indices 0..15 in order, no loss or duplicate; done after the 16th.
4. relu_en=1, shamt=0: -5 → 0, 5 → 5, -128 → 0, 127 → 127.
5. Reset asserted between clock edges after 5 handshakes → out_valid, busy and out_data go 0 immediately; new start with fresh sums streams from index 0 with the new values.
6. start re-pulsed and pe_sums changed during STREAM → ignored; stream still emits the original snapshot, and exactly one done.

Source files
------------

// File: rtl/pe_drain_pkg.sv
// rtl/pe_drain_pkg.sv - shared state encoding and quantizer constants for pe_sum_drain
package pe_drain_pkg;

    localparam int DEF_IN_W  = 20;
    localparam int DEF_OUT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } drain_state_e;

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

    localparam int SAT_MAX = sat_max(DEF_OUT_W);
    localparam int SAT_MIN = sat_min(DEF_OUT_W);

endpackage

// File: rtl/pe_sum_quant.sv
// rtl/pe_sum_quant.sv - arithmetic shift, optional relu and signed saturation of one sum
module pe_sum_quant
    import pe_drain_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic [IN_W-1:0]  sum,
    input  logic [4:0]       shamt,
    input  logic             relu_en,
    output logic [OUT_W-1:0] result
);

    localparam logic signed [IN_W-1:0] MAX_V = IN_W'(sat_max(OUT_W));
    localparam logic signed [IN_W-1:0] MIN_V = IN_W'(sat_min(OUT_W));

    logic signed [IN_W-1:0] shifted;

    // Shifts of IN_W or more collapse to the sign fill (0 or -1).
    always_comb begin
        shifted = $signed(sum) >>> shamt;
        if (relu_en && shifted[IN_W-1]) begin
            shifted = '0;
        end
        if (shifted > MAX_V) begin
            result = MAX_V[OUT_W-1:0];
        end else if (shifted < MIN_V) begin
            result = MIN_V[OUT_W-1:0];
        end else begin
            result = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/pe_sum_drain.sv
// rtl/pe_sum_drain.sv - snapshot a row of PE sums and stream quantized results
module pe_sum_drain
    import pe_drain_pkg::*;
#(
    parameter int NUM_PE = 16,
    parameter int IN_W   = DEF_IN_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int IDX_W  = $clog2(NUM_PE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_PE*IN_W-1:0] pe_sums,
    input  logic [4:0]             shamt,
    input  logic                   relu_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);

    drain_state_e state_q;
    drain_state_e state_d;

    logic [IN_W-1:0]  snap_q [NUM_PE];
    logic [IDX_W-1:0] idx_q;
    logic [4:0]       shamt_q;
    logic             relu_q;
    logic [OUT_W-1:0] quant_data;
    logic             last_elem;
    logic             handshake;

    assign last_elem = (idx_q == IDX_W'(NUM_PE - 1));
    assign handshake = (state_q == STREAM) && out_ready;

    pe_sum_quant #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_quant (
        .sum     (snap_q[idx_q]),
        .shamt   (shamt_q),
        .relu_en (relu_q),
        .result  (quant_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shamt_q <= '0;
            relu_q  <= 1'b0;
            for (int i = 0; i < NUM_PE; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                idx_q   <= '0;
                shamt_q <= shamt;
                relu_q  <= relu_en;
                for (int i = 0; i < NUM_PE; i++) begin
                    snap_q[i] <= pe_sums[i*IN_W +: IN_W];
                end
            end else if (handshake && !last_elem) begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    // Outputs decode only registered state; out_ready only steers the next state.
    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                out_data  = quant_data;
                out_idx   = idx_q;
                out_last  = last_elem;
                busy      = 1'b1;
                if (handshake && last_elem) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pe_sum_drain.sv
// tb/tb_pe_sum_drain.sv - scoreboard bench for pe_sum_drain
module tb_pe_sum_drain;

    localparam int NUM_PE = 16;
    localparam int IN_W   = 20;
    localparam int OUT_W  = 8;
    localparam int IDX_W  = 4;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [IDX_W-1:0] idx;
        logic             last;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   start = 1'b0;
    logic [NUM_PE*IN_W-1:0] pe_sums = '0;
    logic [4:0]             shamt = '0;
    logic                   relu_en = 1'b0;
    logic                   out_ready = 1'b0;
    logic                   out_valid;
    logic [OUT_W-1:0]       out_data;
    logic [IDX_W-1:0]       out_idx;
    logic                   out_last;
    logic                   busy;
    logic                   done;

    exp_t exp_q[$];
    int   sums[NUM_PE];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   exp_done = 0;
    int   done_count = 0;
    int   hs_total = 0;
    int   idx0_cyc = -1;
    int   done_cyc = -1;
    int   ready_mode = 0;
    bit   tog = 1'b0;

    pe_sum_drain dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pe_sums   (pe_sums),
        .shamt     (shamt),
        .relu_en   (relu_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin
                tog = ~tog;
                out_ready = tog;
            end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Floor division by 2^sh, then relu and clamp to the signed OUT_W range.
    function automatic int model_q(input int x, input int sh, input bit relu);
        longint s;
        if (sh >= IN_W) begin
            s = (x < 0) ? -1 : 0;
        end else begin
            longint d = longint'(1) << sh;
            s = x / d;
            if (x < 0 && (x % d) != 0) s = s - 1;
        end
        if (relu && s < 0) s = 0;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return int'(s);
    endfunction

    task automatic drive_sums();
        for (int i = 0; i < NUM_PE; i++) begin
            pe_sums[i*IN_W +: IN_W] = IN_W'(sums[i]);
        end
    endtask

    task automatic rand_sums();
        for (int i = 0; i < NUM_PE; i++) begin
            sums[i] = int'($urandom_range(0, 20'hFFFFF)) - (1 << 19);
        end
    endtask

    task automatic issue(input int sh, input bit relu, output int c0);
        exp_t e;
        @(posedge clk);
        #1;
        drive_sums();
        for (int i = 0; i < NUM_PE; i++) begin
            e.data = OUT_W'(model_q(sums[i], sh, relu));
            e.idx  = IDX_W'(i);
            e.last = (i == NUM_PE - 1);
            exp_q.push_back(e);
        end
        shamt   = 5'(sh);
        relu_en = relu;
        start   = 1'b1;
        c0      = cyc;
        exp_done++;
        @(posedge clk);
        #1;
        start   = 1'b0;
        shamt   = 5'($urandom);
        relu_en = 1'($urandom);
        rand_sums();
        drive_sums();
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_count < exp_done && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, done_count, exp_done);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard on each handshake, checks hold-stability and done timing.
    logic             held_v = 1'b0;
    logic [OUT_W-1:0] held_data;
    logic [IDX_W-1:0] held_idx;
    logic             held_last;
    logic             done_due = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            held_v   = 1'b0;
            done_due = 1'b0;
        end else begin
            if (done) begin
                done_count++;
                done_cyc = cyc;
                check("done_busy", busy, 1);
                check("done_valid_low", out_valid, 0);
            end
            if (done_due || done) begin
                check("done_timing", done, done_due);
            end
            done_due = 1'b0;
            if (held_v && out_valid) begin
                check("hold_data", out_data, held_data);
                check("hold_idx", out_idx, held_idx);
                check("hold_last", out_last, held_last);
            end
            held_v    = out_valid && !out_ready;
            held_data = out_data;
            held_idx  = out_idx;
            held_last = out_last;
            if (out_valid && out_ready) begin
                hs_total++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: idx %0d data %0d with empty scoreboard", out_idx, out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_idx", out_idx, e.idx);
                    check("out_last", out_last, e.last);
                    check("stream_busy", busy, 1);
                    if (e.idx == 0) idx0_cyc = cyc;
                    done_due = out_last;
                end
            end
        end
    end

    initial begin
        int c0;
        int base;
        int n;

        #2;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", out_data, 0);
        check("rst_idx", out_idx, 0);
        check("rst_last", out_last, 0);
        @(negedge clk);
        reset = 1'b0;

        // Ramp, full throughput, latency and done position
        ready_mode = 0;
        for (int i = 0; i < NUM_PE; i++) sums[i] = i;
        issue(0, 1'b0, c0);
        wait_done("ramp_done");
        check("first_valid_latency", idx0_cyc, c0 + 1);
        check("done_cycle", done_cyc, c0 + 17);

        // Saturation with shamt 4 and shamt 1
        rand_sums();
        sums[0] = 20'h7FFFF;
        sums[1] = -(1 << 19);
        issue(4, 1'b0, c0);
        wait_done("sat4_done");
        rand_sums();
        sums[0] = 300;
        sums[1] = -256;
        sums[2] = -3;
        issue(1, 1'b0, c0);
        wait_done("sat1_done");

        // Alternating backpressure
        ready_mode = 1;
        rand_sums();
        issue(6, 1'b0, c0);
        wait_done("bp_done");

        // Relu
        ready_mode = 0;
        rand_sums();
        sums[0] = -5;
        sums[1] = 5;
        sums[2] = -128;
        sums[3] = 127;
        issue(0, 1'b1, c0);
        wait_done("relu_done");

        // Asynchronous reset after five handshakes, then restart from index 0
        rand_sums();
        base = hs_total;
        issue(3, 1'b0, c0);
        n = 0;
        while (hs_total < base + 5 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reset_reach_5", hs_total >= base + 5, 1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", out_data, 0);
        exp_q.delete();
        exp_done--;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_no_done", done_count, exp_done);
        rand_sums();
        issue(2, 1'b1, c0);
        wait_done("after_rst_done");

        // Start re-pulsed and sums changed during the stream
        ready_mode = 2;
        rand_sums();
        issue(5, 1'b0, c0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        rand_sums();
        drive_sums();
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore_start_done");
        repeat (25) @(posedge clk);
        #1;
        check("single_done", done_count, exp_done);

        // Randomized streams
        for (int k = 0; k < 6; k++) begin
            ready_mode = (k % 3);
            rand_sums();
            issue(int'($urandom_range(0, 23)), 1'($urandom), c0);
            wait_done("rand_done");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
